// File: rtl/jhash_stream_if.sv
// Handshake/bus bundle for the streaming lookup3 hash engine.
// master = requester (key fetch side), slave = hash engine.
interface jhash_stream_if #(
    parameter int unsigned LEN_W = 16
) ();
    logic             start;
    logic [31:0]      initval;
    logic [LEN_W-1:0] len_words;
    logic [31:0]      key_data;
    logic             key_valid;
    logic             key_ready;
    logic             busy;
    logic             done;
    logic [31:0]      hash_c;
    logic [31:0]      hash_b;

    modport master (
        output start, initval, len_words, key_data, key_valid,
        input  key_ready, busy, done, hash_c, hash_b
    );

    modport slave (
        input  start, initval, len_words, key_data, key_valid,
        output key_ready, busy, done, hash_c, hash_b
    );
endinterface

// File: rtl/jhash_stream.sv
// Streaming Jenkins lookup3 hashword/hashword2 engine: key words arrive over valid/ready,
// mix/final run either one step per clock (UNROLL=0) or fully in one clock (UNROLL=1).
module jhash_stream #(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned UNROLL = 0
) (
    input  logic           clk,
    input  logic           rst,
    jhash_stream_if.slave  bus
);
    localparam int unsigned MIX_STEPS   = 6;
    localparam int unsigned FINAL_STEPS = 7;

    typedef enum logic [2:0] {IDLE, LOAD, MIX, FINAL, DONE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      a, b, c, a_nxt, b_nxt, c_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [1:0]       word_idx, word_idx_nxt;
    logic [2:0]       step, step_nxt;
    logic [31:0]      init_val;
    logic [95:0]      abc;
    logic             key_ready_q, busy_q, done_q;
    logic [31:0]      hash_c_q, hash_b_q, hash_c_nxt, hash_b_nxt;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [95:0] mix_step(input logic [2:0] s, input logic [95:0] v);
        logic [31:0] x, y, z;
        {x, y, z} = v;
        case (s)
            3'd0:    begin x = x - z; x = x ^ rotl(z, 4);  z = z + y; end
            3'd1:    begin y = y - x; y = y ^ rotl(x, 6);  x = x + z; end
            3'd2:    begin z = z - y; z = z ^ rotl(y, 8);  y = y + x; end
            3'd3:    begin x = x - z; x = x ^ rotl(z, 16); z = z + y; end
            3'd4:    begin y = y - x; y = y ^ rotl(x, 19); x = x + z; end
            default: begin z = z - y; z = z ^ rotl(y, 4);  y = y + x; end
        endcase
        return {x, y, z};
    endfunction

    function automatic logic [95:0] final_step(input logic [2:0] s, input logic [95:0] v);
        logic [31:0] x, y, z;
        {x, y, z} = v;
        case (s)
            3'd0:    begin z = z ^ y; z = z - rotl(y, 14); end
            3'd1:    begin x = x ^ z; x = x - rotl(z, 11); end
            3'd2:    begin y = y ^ x; y = y - rotl(x, 25); end
            3'd3:    begin z = z ^ y; z = z - rotl(y, 16); end
            3'd4:    begin x = x ^ z; x = x - rotl(z, 4);  end
            3'd5:    begin y = y ^ x; y = y - rotl(x, 14); end
            default: begin z = z ^ y; z = z - rotl(y, 24); end
        endcase
        return {x, y, z};
    endfunction

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_nxt     = state;
        a_nxt         = a;
        b_nxt         = b;
        c_nxt         = c;
        remaining_nxt = remaining;
        word_idx_nxt  = word_idx;
        step_nxt      = step;
        init_val      = 32'hdeadbeef + 32'({bus.len_words, 2'b00}) + bus.initval;
        abc           = {a, b, c};
        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_nxt         = init_val;
                    b_nxt         = init_val;
                    c_nxt         = init_val;
                    remaining_nxt = bus.len_words;
                    word_idx_nxt  = 2'd0;
                    step_nxt      = 3'd0;
                    state_nxt     = (bus.len_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (bus.key_valid) begin
                    case (word_idx)
                        2'd0:    a_nxt = a + bus.key_data;
                        2'd1:    b_nxt = b + bus.key_data;
                        default: c_nxt = c + bus.key_data;
                    endcase
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining_nxt == '0) begin
                        state_nxt = FINAL;
                    end else if (word_idx == 2'd2) begin
                        state_nxt    = MIX;
                        word_idx_nxt = 2'd0;
                    end else begin
                        word_idx_nxt = word_idx + 2'd1;
                    end
                end
            end
            MIX: begin
                if (UNROLL != 0) begin
                    for (int i = 0; i < int'(MIX_STEPS); i++) abc = mix_step(3'(i), abc);
                    state_nxt = LOAD;
                end else begin
                    abc = mix_step(step, abc);
                    if (step == 3'(MIX_STEPS - 1)) begin
                        state_nxt = LOAD;
                        step_nxt  = 3'd0;
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end
                {a_nxt, b_nxt, c_nxt} = abc;
            end
            FINAL: begin
                if (UNROLL != 0) begin
                    for (int i = 0; i < int'(FINAL_STEPS); i++) abc = final_step(3'(i), abc);
                    state_nxt = DONE;
                end else begin
                    abc = final_step(step, abc);
                    if (step == 3'(FINAL_STEPS - 1)) begin
                        state_nxt = DONE;
                        step_nxt  = 3'd0;
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end
                {a_nxt, b_nxt, c_nxt} = abc;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Results are captured on entry to DONE so they are valid in the done cycle
        hash_c_nxt = (state_nxt == DONE) ? c_nxt : hash_c_q;
        hash_b_nxt = (state_nxt == DONE) ? b_nxt : hash_b_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            remaining   <= '0;
            word_idx    <= '0;
            step        <= '0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hash_c_q    <= '0;
            hash_b_q    <= '0;
        end else begin
            state       <= state_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            c           <= c_nxt;
            remaining   <= remaining_nxt;
            word_idx    <= word_idx_nxt;
            step        <= step_nxt;
            key_ready_q <= (state_nxt == LOAD);
            busy_q      <= (state_nxt != IDLE);
            done_q      <= (state_nxt == DONE);
            hash_c_q    <= hash_c_nxt;
            hash_b_q    <= hash_b_nxt;
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hash_c    = hash_c_q;
    assign bus.hash_b    = hash_b_q;
endmodule

// File: tb/tb_jhash_stream.sv
// Self-checking bench for jhash_stream: both UNROLL variants against a C-style lookup3 model.
module tb_jhash_stream;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, sel, key_valid;
    logic [31:0]      initval, key_data;
    logic [LEN_W-1:0] len_words;
    logic             ready, busy, done;
    logic [31:0]      hc, hb;

    int checks = 0;
    int passes = 0;
    logic [31:0] kw [0:299];

    always #5 clk = ~clk;

    jhash_stream_if #(.LEN_W(LEN_W)) if0 ();
    jhash_stream_if #(.LEN_W(LEN_W)) if1 ();

    assign if0.start     = start & ~sel;
    assign if1.start     = start & sel;
    assign if0.key_valid = key_valid & ~sel;
    assign if1.key_valid = key_valid & sel;
    assign if0.initval   = initval;
    assign if1.initval   = initval;
    assign if0.len_words = len_words;
    assign if1.len_words = len_words;
    assign if0.key_data  = key_data;
    assign if1.key_data  = key_data;

    assign ready = sel ? if1.key_ready : if0.key_ready;
    assign busy  = sel ? if1.busy      : if0.busy;
    assign done  = sel ? if1.done      : if0.done;
    assign hc    = sel ? if1.hash_c    : if0.hash_c;
    assign hb    = sel ? if1.hash_b    : if0.hash_b;

    jhash_stream #(.LEN_W(LEN_W), .UNROLL(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    jhash_stream #(.LEN_W(LEN_W), .UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s (unroll=%0d): got %h expected %h", name, sel, got, exp);
    endtask

    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // lookup3 hashword2 with pb=0, written the way the C reference is structured
    function automatic logic [63:0] ref_hash(input int n, input logic [31:0] iv);
        logic [31:0] ra, rb, rc;
        int len, i;
        ra = 32'hdeadbeef + 32'(n * 4) + iv;
        rb = ra;
        rc = ra;
        len = n;
        i = 0;
        while (len > 3) begin
            ra += kw[i]; rb += kw[i+1]; rc += kw[i+2];
            ra -= rc; ra ^= rot(rc, 4);  rc += rb;
            rb -= ra; rb ^= rot(ra, 6);  ra += rc;
            rc -= rb; rc ^= rot(rb, 8);  rb += ra;
            ra -= rc; ra ^= rot(rc, 16); rc += rb;
            rb -= ra; rb ^= rot(ra, 19); ra += rc;
            rc -= rb; rc ^= rot(rb, 4);  rb += ra;
            len -= 3;
            i += 3;
        end
        if (len == 0) return {rb, rc};
        if (len == 3) rc += kw[i+2];
        if (len >= 2) rb += kw[i+1];
        ra += kw[i];
        rc ^= rb; rc -= rot(rb, 14);
        ra ^= rc; ra -= rot(rc, 11);
        rb ^= ra; rb -= rot(ra, 25);
        rc ^= rb; rc -= rot(rb, 16);
        ra ^= rc; ra -= rot(rc, 4);
        rb ^= ra; rb -= rot(ra, 14);
        rc ^= rb; rc -= rot(rb, 24);
        return {rb, rc};
    endfunction

    task automatic fill_words(input int n);
        for (int i = 0; i < n; i++) kw[i] = $urandom;
    endtask

    // Runs one hash; lat is the cycle (edge 0 = start sample) in which done is seen
    task automatic run_hash(input int n, input logic [31:0] iv, input bit gaps, input int gap_at,
                            input bit poke_start, input logic [31:0] held_c, input logic [31:0] held_b,
                            output logic [31:0] rc, output logic [31:0] rb, output int lat,
                            output bit ready_seen);
        int idx, cyc, stall;
        bit v, stalled, acc;
        rc = '0; rb = '0; lat = -1; ready_seen = 0;
        idx = 0; stall = 10;
        @(negedge clk);
        start = 1'b1; initval = iv; len_words = LEN_W'(n); key_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 6000) begin
            v = (idx < n);
            if (v && gaps && $urandom_range(2) == 0) v = 1'b0;
            stalled = 1'b0;
            if (v && idx == gap_at && stall > 0) begin
                v = 1'b0;
                stall--;
                stalled = 1'b1;
            end
            key_valid = v;
            key_data  = (idx < n) ? kw[idx] : $urandom;
            @(negedge clk);
            if (stalled) check("stall_ready", 32'(ready), 32'd1);
            if (ready) ready_seen = 1'b1;
            if (done) begin
                lat = cyc;
                rc = hc;
                rb = hb;
                break;
            end
            if (poke_start && busy && !ready) begin
                check("held_c", hc, held_c);
                check("held_b", hb, held_b);
                start = 1'b1;
                initval = $urandom;
                len_words = LEN_W'($urandom);
            end
            acc = v && ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            cyc++;
        end
        key_valid = 1'b0;
        if (lat < 0) check("timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int          n;
        logic [31:0] iv;
        bit          fixed_words;
        int          lat0;
        int          lat1;
        bit          use_const;
        logic [31:0] exp_c;
        logic [31:0] exp_b;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        int          lens [6];
        logic [63:0] m;
        logic [31:0] rc, rb, rc2, rb2, iv, prev_c, prev_b;
        int          lat, lat2;
        bit          rs;

        vecs[0] = '{0, 32'h0,        1'b0, 1,  1, 1'b1, 32'hdeadbeef, 32'hdeadbeef};
        vecs[1] = '{3, 32'h0,        1'b1, 11, 5, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1, 32'h12345678, 1'b0, 9,  3, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{2, 32'hcafef00d, 1'b0, 10, 4, 1'b0, 32'h0, 32'h0};
        vecs[4] = '{4, 32'h0badc0de, 1'b0, 18, 7, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{6, 32'hffffffff, 1'b0, 20, 9, 1'b0, 32'h0, 32'h0};
        lens = '{1, 2, 4, 6, 7, 255};

        rst = 1'b1; start = 1'b0; sel = 1'b0; key_valid = 1'b0;
        initval = '0; len_words = '0; key_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_ready", 32'(ready), 32'd0);
            check("rst_busy",  32'(busy),  32'd0);
            check("rst_done",  32'(done),  32'd0);
            check("rst_hash_c", hc, 32'd0);
            check("rst_hash_b", hb, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            // Directed table: latency and result for short keys
            foreach (vecs[k]) begin
                if (vecs[k].fixed_words) begin
                    kw[0] = 32'h61616161; kw[1] = 32'h62626262; kw[2] = 32'h63636363;
                end else begin
                    fill_words(vecs[k].n);
                end
                m = ref_hash(vecs[k].n, vecs[k].iv);
                if (vecs[k].use_const) m = {vecs[k].exp_b, vecs[k].exp_c};
                run_hash(vecs[k].n, vecs[k].iv, 1'b0, -1, 1'b0, '0, '0, rc, rb, lat, rs);
                check("vec_hash_c", rc, m[31:0]);
                check("vec_hash_b", rb, m[63:32]);
                check("vec_latency", 32'(lat), 32'(s == 0 ? vecs[k].lat0 : vecs[k].lat1));
                if (vecs[k].n == 0) check("len0_ready_never", 32'(rs), 32'd0);
            end

            // Random keys with random valid gaps
            for (int k = 0; k < 10; k++) begin
                int n;
                n = (k < 6) ? lens[k] : int'($urandom_range(40, 1));
                iv = $urandom;
                fill_words(n);
                m = ref_hash(n, iv);
                run_hash(n, iv, 1'b1, -1, 1'b0, '0, '0, rc, rb, lat, rs);
                check("rand_hash_c", rc, m[31:0]);
                check("rand_hash_b", rb, m[63:32]);
            end

            // Ten-cycle valid stall after two words must only delay the result
            iv = $urandom;
            fill_words(6);
            m = ref_hash(6, iv);
            run_hash(6, iv, 1'b0, -1, 1'b0, '0, '0, rc, rb, lat, rs);
            run_hash(6, iv, 1'b0, 2, 1'b0, '0, '0, rc2, rb2, lat2, rs);
            check("stall_hash_c", rc2, rc);
            check("stall_hash_b", rb2, rb);
            check("stall_model_c", rc2, m[31:0]);
            check("stall_latency", 32'(lat2), 32'(lat + 10));
            prev_c = rc2;
            prev_b = rb2;

            // start pulses during MIX/FINAL are ignored and old results hold until done
            iv = $urandom;
            fill_words(7);
            m = ref_hash(7, iv);
            run_hash(7, iv, 1'b0, -1, 1'b1, prev_c, prev_b, rc, rb, lat, rs);
            check("poke_hash_c", rc, m[31:0]);
            check("poke_hash_b", rb, m[63:32]);
            @(negedge clk);
            check("poke_idle_busy", 32'(busy), 32'd0);
            check("poke_hold_c", hc, m[31:0]);

            // Reset mid-hash aborts at once; the next hash is unaffected
            @(negedge clk);
            start = 1'b1; initval = $urandom; len_words = LEN_W'(9);
            @(posedge clk); #1;
            start = 1'b0;
            key_valid = 1'b1;
            repeat (4) begin
                key_data = $urandom;
                @(posedge clk); #1;
            end
            @(negedge clk);
            rst = 1'b1;
            #1;
            key_valid = 1'b0;
            check("abort_ready", 32'(ready), 32'd0);
            check("abort_busy",  32'(busy),  32'd0);
            check("abort_done",  32'(done),  32'd0);
            check("abort_hash_c", hc, 32'd0);
            check("abort_hash_b", hb, 32'd0);
            repeat (2) begin
                @(negedge clk);
                check("abort_no_done", 32'(done), 32'd0);
            end
            rst = 1'b0;
            iv = $urandom;
            fill_words(3);
            m = ref_hash(3, iv);
            run_hash(3, iv, 1'b0, -1, 1'b0, '0, '0, rc, rb, lat, rs);
            check("post_rst_hash_c", rc, m[31:0]);
            check("post_rst_hash_b", rb, m[63:32]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
